stack_row_sequencer: RTL and testbench

//  Game controller for the stacker display. Runs the moving block for the active row and

---
 rtl/stack_row_sequencer.sv | 176 +++++++++++++++++
 tb/tb_stack_row_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/stack_row_sequencer.sv
// Stacker game controller: bounces the active row's block, trims it against the row below on a
// stop press, and drives the flattened stack image plus win/lose flags.
module stack_row_sequencer #(
  parameter int ROWS     = 8,
  parameter int WIDTH    = 8,
  parameter int INIT_LEN = 3,
  parameter int BASE_DIV = 12,
  parameter int DIV_STEP = 1,
  parameter int MIN_DIV  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    startSw,
  input  logic                    stopBtn,
  input  logic                    tickEn,
  output logic [ROWS*WIDTH-1:0]   rowData,
  output logic [$clog2(ROWS)-1:0] activeRow,
  output logic                    gameOver,
  output logic                    gameWon
);
  localparam int LW = $clog2(WIDTH + 1);
  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = $clog2(BASE_DIV + 1);
  localparam int AW = $clog2(ROWS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_ADVANCE = 3'd4;
  localparam logic [2:0] S_LOSE    = 3'd5;
  localparam logic [2:0] S_WIN     = 3'd6;

  logic [2:0]       state;
  logic [WIDTH-1:0] stack [ROWS];
  logic [LW-1:0]    len;
  logic [PW-1:0]    pos;
  logic             dir;
  logic [DW-1:0]    cur_div;
  logic [DW-1:0]    div_cnt;
  logic             stop_prev;

  logic             press;
  logic             live;
  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] below;
  logic [WIDTH-1:0] overlap;
  logic [LW-1:0]    overlap_cnt;
  logic [PW-1:0]    pos_start;
  logic [DW-1:0]    div_next;

  assign press     = stop_prev & ~stopBtn;
  assign live      = (state == S_LOAD) || (state == S_SHIFT) || (state == S_CHECK);
  assign pos_start = PW'(WIDTH - int'(len));
  assign div_next  = (int'(cur_div) >= DIV_STEP + MIN_DIV) ? DW'(int'(cur_div) - DIV_STEP)
                                                           : DW'(MIN_DIV);
  assign below     = (activeRow == '0) ? '1 : stack[activeRow - 1'b1];
  assign overlap   = pattern & below;

  always_comb begin
    pattern = '0;
    for (int i = 0; i < WIDTH; i++)
      pattern[i] = (i >= int'(pos)) && (i < int'(pos) + int'(len));
  end

  always_comb begin
    overlap_cnt = '0;
    for (int i = 0; i < WIDTH; i++)
      overlap_cnt = overlap_cnt + LW'(overlap[i]);
  end

  // Rows below the active one are committed, rows above are blank; the active row is live
  // while the block is still in play and otherwise shows its committed value (0 after a miss).
  always_comb begin
    rowData = '1;
    if (state != S_IDLE) begin
      for (int r = 0; r < ROWS; r++) begin
        if (r < int'(activeRow))
          rowData[r*WIDTH +: WIDTH] = stack[r];
        else if (r == int'(activeRow))
          rowData[r*WIDTH +: WIDTH] = live ? pattern : stack[r];
        else
          rowData[r*WIDTH +: WIDTH] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    stop_prev <= rst ? 1'b1 : stopBtn;
    if (rst || !startSw) begin
      state     <= S_IDLE;
      len       <= LW'(INIT_LEN);
      cur_div   <= DW'(BASE_DIV);
      div_cnt   <= '0;
      activeRow <= '0;
      pos       <= '0;
      dir       <= 1'b0;
      gameOver  <= 1'b0;
      gameWon   <= 1'b0;
      for (int r = 0; r < ROWS; r++) stack[r] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state     <= S_LOAD;
          activeRow <= '0;
          len       <= LW'(INIT_LEN);
          cur_div   <= DW'(BASE_DIV);
          pos       <= PW'(WIDTH - INIT_LEN);
          dir       <= 1'b0;
          div_cnt   <= '0;
        end
        S_LOAD: begin
          pos     <= pos_start;
          dir     <= 1'b0;
          div_cnt <= '0;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          // A press in the same cycle as a move freezes the block where the player saw it.
          if (press) begin
            state <= S_CHECK;
          end else if (tickEn) begin
            if (div_cnt == cur_div - 1'b1) begin
              div_cnt <= '0;
              if (int'(len) == WIDTH) begin
                pos <= '0;
              end else if (!dir) begin
                if (pos == '0) begin
                  dir <= 1'b1;
                  pos <= PW'(1);
                end else begin
                  pos <= pos - 1'b1;
                end
              end else begin
                if (pos == pos_start) begin
                  dir <= 1'b0;
                  pos <= pos - 1'b1;
                end else begin
                  pos <= pos + 1'b1;
                end
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (overlap == '0) begin
            state <= S_LOSE;
          end else begin
            stack[activeRow] <= overlap;
            len              <= overlap_cnt;
            state            <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          if (activeRow == AW'(ROWS - 1)) begin
            state   <= S_WIN;
            gameWon <= 1'b1;
          end else begin
            activeRow <= activeRow + 1'b1;
            cur_div   <= div_next;
            pos       <= pos_start;
            dir       <= 1'b0;
            div_cnt   <= '0;
            state     <= S_LOAD;
          end
        end
        // Flag lags LOSE entry by one cycle so both outcomes appear three cycles after the press.
        S_LOSE:  gameOver <= 1'b1;
        S_WIN:   gameWon  <= 1'b1;
        default: state    <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_row_sequencer.sv
// Randomized scoreboard bench: an in-bench game model predicts display and flags each cycle;
// a negedge monitor pops each prediction and compares it with the DUT.
`timescale 1ns/1ps
module tb_stack_row_sequencer;
  localparam int ROWS = 8, WIDTH = 8, INIT_LEN = 3, BASE_DIV = 2, DIV_STEP = 1, MIN_DIV = 1;
  localparam int AW = $clog2(ROWS);

  logic clk = 1'b0, rst = 1'b1, startSw = 1'b0, stopBtn = 1'b1, tickEn = 1'b1;
  logic [ROWS*WIDTH-1:0] rowData;
  logic [AW-1:0] activeRow;
  logic gameOver, gameWon;

  stack_row_sequencer #(.ROWS(ROWS), .WIDTH(WIDTH), .INIT_LEN(INIT_LEN), .BASE_DIV(BASE_DIV),
                        .DIV_STEP(DIV_STEP), .MIN_DIV(MIN_DIV)) dut (
    .clk(clk), .rst(rst), .startSw(startSw), .stopBtn(stopBtn), .tickEn(tickEn),
    .rowData(rowData), .activeRow(activeRow), .gameOver(gameOver), .gameWon(gameWon));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ROWS*WIDTH-1:0] rd;
    logic [AW-1:0]         ar;
    logic                  ov;
    logic                  wn;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;

  typedef enum int {M_IDLE, M_LOAD, M_MOVE, M_CHECK, M_ADV, M_LOST, M_WON} phase_t;
  phase_t ph = M_IDLE;
  int row = 0, m_len = INIT_LEN, m_div = BASE_DIV, ticks = 0;
  int wins = 0, losses = 0, tick_pct = 100;
  logic prev = 1'b1, over = 1'b0, won = 1'b0;
  logic [WIDTH-1:0] stack [ROWS];
  logic [WIDTH-1:0] cap = '0;

  // Block position as a triangle wave of completed moves, starting at the far end.
  function automatic int cur_pos();
    int span, k;
    span = WIDTH - m_len;
    if (span == 0) return 0;
    k = (ticks / m_div) % (2 * span);
    return (k <= span) ? span - k : k - span;
  endfunction

  function automatic logic [WIDTH-1:0] cur_pat();
    logic [WIDTH-1:0] ones;
    ones = WIDTH'((1 << m_len) - 1);
    return ones << cur_pos();
  endfunction

  always @(posedge clk) begin
    exp_t e;
    logic pr;
    logic [WIDTH-1:0] below, ovl;
    if (rst || !startSw) begin
      ph = M_IDLE; row = 0; m_len = INIT_LEN; m_div = BASE_DIV; ticks = 0;
      over = 1'b0; won = 1'b0;
      for (int r = 0; r < ROWS; r++) stack[r] = '0;
      prev = rst ? 1'b1 : stopBtn;
    end else begin
      pr = prev && !stopBtn;
      prev = stopBtn;
      case (ph)
        M_IDLE: begin ph = M_LOAD; row = 0; m_len = INIT_LEN; m_div = BASE_DIV; ticks = 0; end
        M_LOAD: begin ph = M_MOVE; ticks = 0; end
        M_MOVE: begin
          if (pr) begin cap = cur_pat(); ph = M_CHECK; end
          else if (tickEn) ticks++;
        end
        M_CHECK: begin
          below = '1;
          if (row > 0) below = stack[row-1];
          ovl = cap & below;
          if (ovl == '0) begin ph = M_LOST; losses++; end
          else begin stack[row] = ovl; m_len = $countones(ovl); ph = M_ADV; end
        end
        M_ADV: begin
          if (row == ROWS - 1) begin ph = M_WON; won = 1'b1; wins++; end
          else begin
            row++;
            m_div = (m_div - DIV_STEP < MIN_DIV) ? MIN_DIV : m_div - DIV_STEP;
            ticks = 0;
            ph = M_LOAD;
          end
        end
        M_LOST: over = 1'b1;
        default: ;
      endcase
    end
    e.rd = '0;
    if (ph == M_IDLE) e.rd = '1;
    else begin
      for (int r = 0; r < ROWS; r++) begin
        if (r < row) e.rd[r*WIDTH +: WIDTH] = stack[r];
        else if (r == row)
          e.rd[r*WIDTH +: WIDTH] = (ph == M_LOAD || ph == M_MOVE) ? cur_pat() :
                                   (ph == M_CHECK) ? cap : stack[r];
      end
    end
    e.ar = AW'(row);
    e.ov = over;
    e.wn = won;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rowData !== e.rd || activeRow !== e.ar || gameOver !== e.ov || gameWon !== e.wn) begin
        errors++;
        $display("FAIL cycle_out t=%0t got rowData=%h activeRow=%0d gameOver=%b gameWon=%b want rowData=%h activeRow=%0d gameOver=%b gameWon=%b",
                 $time, rowData, activeRow, gameOver, gameWon, e.rd, e.ar, e.ov, e.wn);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    tickEn = (int'($urandom_range(0, 99)) < tick_pct);
  endtask

  task automatic press(input int hold);
    stopBtn = 1'b0;
    repeat (hold) step();
    stopBtn = 1'b1;
    step();
  endtask

  // style 0: stop aligned with the row below; 1: random stops; 2: startSw drop; 3: rst pulse
  task automatic play_game(input int style);
    int guard;
    logic want;
    startSw = 1'b1;
    guard = 0;
    while (ph != M_LOST && ph != M_WON && guard < 3000) begin
      want = 1'b0;
      if (ph == M_MOVE && prev && stopBtn) begin
        if (style == 0 && row > 0) want = (cur_pat() == stack[row-1]);
        else want = ($urandom_range(0, 5) == 0);
      end
      if (want) press(int'($urandom_range(1, 8)));
      else step();
      guard++;
      if (style >= 2 && ph == M_MOVE && $urandom_range(0, 30) == 0) begin
        if (style == 2) begin startSw = 1'b0; step(); end
        else begin rst = 1'b1; step(); rst = 1'b0; end
        break;
      end
    end
    if (guard >= 3000 && style <= 1) begin
      errors++;
      $display("FAIL game_timeout style=%0d got phase=%0d want game end", style, ph);
    end
    repeat ($urandom_range(2, 6)) step();
    startSw = 1'b0;
    repeat ($urandom_range(1, 3)) step();
  endtask

  initial begin
    rst = 1'b1; startSw = 1'b0; stopBtn = 1'b1; tickEn = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) step();
    for (int g = 0; g < 36; g++) begin
      tick_pct = (g < 4) ? 100 : int'($urandom_range(60, 100));
      play_game(g % 4);
    end
    repeat (3) step();
    checks++;
    if (wins == 0) begin
      errors++;
      $display("FAIL win_reached got wins=%0d want >0", wins);
    end
    checks++;
    if (losses == 0) begin
      errors++;
      $display("FAIL lose_reached got losses=%0d want >0", losses);
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
